// File: rtl/cla_mp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cla_mp_sequencer (with 32-bit cla)
//  Description : Multi-precision add/subtract through a single 32-bit CLA,
//                one word per cycle, LSW first, carry chained in a register.
//  Revision    : 1.0 - initial release
// ============================================================================

module cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s
);
    logic [30:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [7:0]  w_cg;

    assign w_g     = a[30:0] & b[30:0];
    assign w_p     = a ^ b;
    assign w_cg[0] = cin;

    // Two-level lookahead: 4-bit groups, group carries from group G/P.
    for (genvar i = 0; i < 8; i++) begin : g_grp
        localparam int B = 4 * i;
        assign w_c[B]   = w_cg[i];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_cg[i]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_cg[i]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_cg[i]);
        if (i < 7) begin : g_next
            assign w_cg[i+1] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                             | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                             | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                             | (&w_p[B+3:B] & w_cg[i]);
        end
    end

    assign s = w_p ^ w_c;
endmodule

module cla_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                op_sub,
    input  logic [32*WORDS-1:0] a_in,
    input  logic [32*WORDS-1:0] b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] result,
    output logic                carry_out,
    output logic                overflow
);
    localparam int W    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_result;
    logic            r_carry_out;
    logic            r_overflow;

    logic [31:0]     w_a_word;
    logic [31:0]     w_b_word;
    logic [31:0]     w_sum;
    logic            w_c31;
    logic            w_cout;
    logic            w_last;

    assign w_last = (r_idx == c_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_word = r_a[i*32 +: 32];
                w_b_word = r_b[i*32 +: 32];
            end
        end
    end

    cla u_cla (
        .a   (w_a_word),
        .b   (w_b_word),
        .cin (r_carry),
        .s   (w_sum)
    );

    // The adder hides its carry-out; recover bit-31 carry-in from the sum.
    assign w_c31  = w_sum[31] ^ w_a_word[31] ^ w_b_word[31];
    assign w_cout = (w_a_word[31] & w_b_word[31])
                  | ((w_a_word[31] ^ w_b_word[31]) & w_c31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b     <= op_sub ? ~b_in : b_in;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_result[i*32 +: 32] <= w_sum;
                        end
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= w_c31 ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
endmodule
`default_nettype wire

// File: doc/cla_mp_sequencer.md
# cla_mp_sequencer

Multi-precision add/subtract sequencer built around one 32-bit `cla` instance. It accepts WORDS×32-bit operands through a valid/ready handshake and feeds them through the single adder one 32-bit word per cycle, least-significant word first. It chains the carry between words in a register and returns the full-width result, carry-out and signed overflow through a second valid/ready handshake. It sits between the execution-unit operand buffers and the existing 32-bit CLA, so wide arithmetic reuses the adder instead of duplicating it.

## Interface
- WORDS, 4, number of 32-bit words per operand; legal range 1..16; total width W = 32×WORDS.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  sequencer can accept an operand set.
- op_sub  in  1  0 = A+B, 1 = A−B; sampled on the accept edge.
- a_in  in  W  operand A.
- b_in  in  W  operand B.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  A+B or A−B, modulo 2^W.
- carry_out  out  1  carry out of bit W−1; for subtraction, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow of the W-bit operation.

## Operation
- The FSM has three states.
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: on the first edge in IDLE with in_valid=1, the block captures a_in, b_in and op_sub.
  - It registers B as b_in, or ~b_in when subtracting.
  - It sets carry_reg to op_sub, clears word index idx to 0, and enters RUN.
- RUN, one word per cycle:
  - The CLA is driven with a = A word idx, b = B' word idx, cin = carry_reg.
  - On each edge, the CLA sum is written to result word idx.
  - carry_reg is updated to the word carry-out, and idx increments.
- Word carry-out: the CLA exposes no carry-out, so it is reconstructed locally.
  - c31 = s[31]^a[31]^b[31].
  - cout = (a[31]&b[31]) | ((a[31]^b[31]) & c31).
- Top word (idx = WORDS−1), on the same edge as its sum is written:
  - carry_out ← cout.
  - overflow ← c31 ^ cout.
  - The FSM enters DONE.
- DONE: result, carry_out and overflow hold stable while out_ready=0. When out_valid & out_ready, the FSM returns to IDLE.
- There is no same-cycle bypass. in_ready rises on the cycle after the output handshake.
- Result fields keep their last values in IDLE and RUN until overwritten. Consumers qualify them with out_valid only.
- in_valid is ignored outside IDLE. a_in and b_in need not be held after the accept edge.
- Reset, including mid-RUN or mid-DONE: state is forced to IDLE and the in-flight operation is discarded. Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - result = 0.
  - carry_out = 0.
  - overflow = 0.
  - carry_reg = 0 and idx = 0.
- WORDS=1: RUN lasts a single cycle; behaviour is otherwise identical.

## Timing
- Accept edge at T: the first result word is written at T+1, and the top word at T+WORDS.
- out_valid is high in the cycle following edge T+WORDS.
- Minimum issue interval is WORDS+2 cycles with out_ready held high: accept, WORDS RUN edges, DONE handshake.
- in_ready and out_valid are decoded directly from registered state, with no combinational path from in_valid or out_ready.
- The critical path is the CLA plus the cout reconstruction, one adder delay per cycle.

## Test plan
All scenarios use WORDS=4.
- Cross-word carry ripple: A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, add → result=0x0000_0000_0000_0001_0000_0000_0000_0000, carry_out=0, overflow=0. out_valid rises exactly 4 edges after the accept edge.
- Full wrap: A=all ones, B=1, add → result=0, carry_out=1, overflow=0. Also A=0x7FFF_…_FFFF, B=1, add → result=0x8000_…_0000, carry_out=0, overflow=1.
- Subtract: A=0, B=1 → result=all ones, carry_out=0 (borrow), overflow=0. Also A=0x8000_…_0000, B=1 → result=0x7FFF_…_FFFF, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands → result, carry_out and overflow stay stable, and in_ready stays 0. Raising out_ready completes the handshake, and in_ready=1 on the next cycle.
- Back-to-back with out_ready=1: issue 3 random operation pairs checked against a W-bit reference model. Accepts occur every 6 cycles.
- Reset mid-operation: assert rst_n=0 at idx=2 of a RUN → all outputs show reset values immediately with no clock edge. The next operation after release (A=5, B=3, sub) returns result=2, carry_out=1, overflow=0.
